hs_fifo_pkt_guard: RTL and testbench



---
 rtl/hs_fifo_pkt_guard.sv | 142 ++++++++++++++
 tb/tb_hs_fifo_pkt_guard.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_fifo_pkt_guard.sv
// Packet admission stage in front of an async FIFO write port: forwards beats through
// a single register slice, flags bad packets via m_drop, and truncates oversized ones.
module hs_fifo_pkt_guard #(
    parameter type DATA_TYPE   = logic,
    parameter int  MAX_PKT_LEN = 256,
    parameter int  MIN_PKT_LEN = 1,
    parameter int  STAT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  DATA_TYPE              s_data,
    input  logic                  s_last,
    input  logic                  s_err,
    output logic                  m_valid,
    input  logic                  m_ready,
    output DATA_TYPE              m_data,
    output logic                  m_last,
    output logic                  m_drop,
    output logic [STAT_WIDTH-1:0] pkt_ok_cnt,
    output logic [STAT_WIDTH-1:0] pkt_drop_cnt,
    output logic                  busy
);

    localparam int LEN_WIDTH = $clog2(MAX_PKT_LEN + 1);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_PKT_LEN);
    localparam logic [LEN_WIDTH-1:0] MIN_LEN = LEN_WIDTH'(MIN_PKT_LEN);

    typedef enum logic [1:0] {IDLE, ACTIVE, DISCARD} state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic                  m_drop_q, m_drop_d;
    DATA_TYPE              m_data_q, m_data_d;
    logic [STAT_WIDTH-1:0] ok_cnt_q, ok_cnt_d;
    logic [STAT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic                  accept;
    logic [LEN_WIDTH-1:0]  n_beat;
    logic                  e_beat;

    assign s_ready = (state_q == DISCARD) || !m_valid_q || m_ready;
    assign accept  = s_valid && s_ready;
    assign n_beat  = cnt_q + 1'b1;
    assign e_beat  = err_q | s_err;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        m_drop_d   = m_drop_q;
        m_data_d   = m_data_q;
        ok_cnt_d   = ok_cnt_q;
        drop_cnt_d = drop_cnt_q;

        // Output slice drains first; a new beat may reload it in the same cycle.
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            if (m_last_q) begin
                if (m_drop_q) begin
                    if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
                end else begin
                    if (ok_cnt_q != '1) ok_cnt_d = ok_cnt_q + 1'b1;
                end
            end
        end

        if (accept) begin
            if (state_q == DISCARD) begin
                if (s_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end else begin
                m_valid_d = 1'b1;
                m_data_d  = s_data;
                if (s_last) begin
                    m_last_d = 1'b1;
                    m_drop_d = e_beat || (n_beat < MIN_LEN);
                    state_d  = IDLE;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                end else if (n_beat == MAX_LEN) begin
                    m_last_d = 1'b1;
                    m_drop_d = 1'b1;
                    state_d  = DISCARD;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                end else begin
                    m_last_d = 1'b0;
                    m_drop_d = 1'b0;
                    state_d  = ACTIVE;
                    cnt_d    = n_beat;
                    err_d    = e_beat;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_drop_q   <= 1'b0;
            ok_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            m_drop_q   <= m_drop_d;
            ok_cnt_q   <= ok_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Data needs no reset; it is only meaningful while m_valid is high.
    always_ff @(posedge clk) begin
        m_data_q <= m_data_d;
    end

    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign m_last       = m_last_q;
    assign m_drop       = m_drop_q;
    assign pkt_ok_cnt   = ok_cnt_q;
    assign pkt_drop_cnt = drop_cnt_q;
    assign busy         = (state_q != IDLE) || m_valid_q;

endmodule

// File: tb/tb_hs_fifo_pkt_guard.sv
// Bench for hs_fifo_pkt_guard: packet table plus beat scoreboard, with a second
// instance using 2-bit counters to exercise saturation.
module tb_hs_fifo_pkt_guard;

    localparam int MAX = 8;
    localparam int MIN = 2;

    logic       clk = 1'b0;
    logic       aresetn = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       s_last = 1'b0;
    logic       s_err = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_drop;
    logic [31:0] ok_cnt, drop_cnt;
    logic       busy;

    logic       s_ready2, m_valid2, m_last2, m_drop2, busy2;
    logic [7:0] m_data2;
    logic [1:0] ok_cnt2, drop_cnt2;

    int n_cmp = 0;
    int n_fail = 0;
    bit rand_mode = 0;
    logic [7:0] next_data = 8'h10;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       drop;
    } beat_t;
    beat_t exp_q[$];

    typedef struct {
        int len;
        int err_beat;
        int exp_ok;
        int exp_drop;
        int exp_ok2;
        int exp_drop2;
    } pkt_vec_t;
    pkt_vec_t vec[8];

    always #5 clk = ~clk;

    hs_fifo_pkt_guard #(
        .DATA_TYPE(logic [7:0]), .MAX_PKT_LEN(MAX), .MIN_PKT_LEN(MIN), .STAT_WIDTH(32)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_err(s_err),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_drop(m_drop),
        .pkt_ok_cnt(ok_cnt), .pkt_drop_cnt(drop_cnt), .busy(busy)
    );

    hs_fifo_pkt_guard #(
        .DATA_TYPE(logic [7:0]), .MAX_PKT_LEN(MAX), .MIN_PKT_LEN(MIN), .STAT_WIDTH(2)
    ) dut2 (
        .clk(clk), .aresetn(aresetn),
        .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data), .s_last(s_last), .s_err(s_err),
        .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_last(m_last2), .m_drop(m_drop2),
        .pkt_ok_cnt(ok_cnt2), .pkt_drop_cnt(drop_cnt2), .busy(busy2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sink readiness changes only on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            m_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: a beat visible with m_ready high at mid-cycle handshakes on the next edge.
    initial begin
        beat_t exp_b;
        bit stalled = 0;
        logic [7:0] hold_data;
        logic hold_last, hold_drop;
        forever begin
            @(negedge clk);
            #1;
            if (!aresetn) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    check("stall_valid", 32'(m_valid), 32'd1);
                    check("stall_hold", {m_data, 6'd0, m_last, m_drop},
                          {hold_data, 6'd0, hold_last, hold_drop});
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", {m_data, 6'd0, m_last, m_drop}, 32'hFFFF_FFFF);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("beat", {m_data, 6'd0, m_last, m_drop},
                              {exp_b.data, 6'd0, exp_b.last, exp_b.drop});
                    end
                end
                stalled   = m_valid && !m_ready;
                hold_data = m_data;
                hold_last = m_last;
                hold_drop = m_drop;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the handshake.
    task automatic send_beat(input logic [7:0] d, input logic last, input logic err,
                             input bit fwd);
        bit done = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        s_err   = err;
        for (int w = 0; w < 100 && !done; w++) begin
            @(posedge clk);
            if (s_ready) done = 1;
        end
        if (!done) check("handshake_timeout", 32'd0, 32'd1);
        #1;
        if (fwd) check("latency_valid", 32'(m_valid), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_err   = 1'b0;
    endtask

    task automatic applyStimulus(input int len, input int err_beat);
        bit err_seen = 0;
        bit last_o, drop_o;
        beat_t b;
        for (int i = 1; i <= len; i++) begin
            err_seen = err_seen || (i == err_beat);
            if (i <= MAX) begin
                last_o = (i == len) || (i == MAX);
                drop_o = last_o && (err_seen || (i == len && len < MIN) || (i == MAX && len > MAX));
                b.data = next_data;
                b.last = last_o;
                b.drop = drop_o;
                exp_q.push_back(b);
            end
            send_beat(next_data, i == len, i == err_beat, i <= MAX);
            next_data = next_data + 8'd1;
        end
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int w = 0; w < 300 && !done; w++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0 && !m_valid) done = 1;
        end
        if (!done) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic checkOutput(input string tag, input int ok, input int drop,
                               input int ok2, input int drop2);
        check({tag, "_ok"}, ok_cnt, 32'(ok));
        check({tag, "_drop"}, drop_cnt, 32'(drop));
        check({tag, "_ok2"}, 32'(ok_cnt2), 32'(ok2));
        check({tag, "_drop2"}, 32'(drop_cnt2), 32'(drop2));
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vec[0] = '{5,  0, 1, 0, 1, 0};
        vec[1] = '{4,  2, 1, 1, 1, 1};
        vec[2] = '{11, 0, 1, 2, 1, 2};
        vec[3] = '{3,  0, 2, 2, 2, 2};
        vec[4] = '{1,  0, 2, 3, 2, 3};
        vec[5] = '{8,  0, 3, 3, 3, 3};
        vec[6] = '{2,  2, 3, 4, 3, 3};
        vec[7] = '{9,  0, 3, 5, 3, 3};

        repeat (2) @(negedge clk);
        #1;
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_flags", {30'd0, m_last, m_drop}, 32'd0);
        checkOutput("reset", 0, 0, 0, 0);
        check("reset_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            applyStimulus(vec[k].len, vec[k].err_beat);
            wait_drain();
            checkOutput($sformatf("pkt%0d", k), vec[k].exp_ok, vec[k].exp_drop,
                        vec[k].exp_ok2, vec[k].exp_drop2);
        end

        rand_mode = 1;
        for (int k = 0; k < 3; k++) applyStimulus(3, 0);
        wait_drain();
        rand_mode = 0;
        checkOutput("rand", 6, 5, 3, 3);

        // Reset in the middle of a packet whose beat 2 carried an error.
        @(negedge clk);
        applyStimulus(2 + 0, 0);
        wait_drain();
        checkOutput("pre_reset", 7, 5, 3, 3);
        begin
            beat_t b;
            b = '{8'hA1, 1'b0, 1'b0}; exp_q.push_back(b);
            send_beat(8'hA1, 1'b0, 1'b0, 1'b1);
            b = '{8'hA2, 1'b0, 1'b0}; exp_q.push_back(b);
            send_beat(8'hA2, 1'b0, 1'b1, 1'b1);
        end
        s_valid = 1'b1;
        s_data  = 8'hA3;
        #2;
        aresetn = 1'b0;
        #1;
        check("mid_reset_m_valid", 32'(m_valid), 32'd0);
        checkOutput("mid_reset", 0, 0, 0, 0);
        s_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        applyStimulus(3, 0);
        wait_drain();
        checkOutput("post_reset", 1, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
